// File: rtl/mp3_pkg.sv
// mp3_pkg -- shared constants, types and helpers for the scalefactor store.
//   SF_W                  default bits per scalefactor
//   NUM_SFB_L / NUM_SFB_S long / short scalefactor band counts
//   NUM_WIN               windows per short band
//   SCFSI_G*_FIRST        first long band of each scfsi reuse group
//   MIXED_*               long/short split of a mixed block
//   sf_l_t / sf_s_t       packed scalefactor sets at the default width
//   state_t               stream FSM states
//   scfsi_group()         long band index -> scfsi group
package mp3_pkg;

   localparam int SF_W      = 4;
   localparam int NUM_SFB_L = 21;
   localparam int NUM_SFB_S = 12;
   localparam int NUM_WIN   = 3;
   localparam int BAND_W    = 5;
   localparam int WIN_W     = 2;

   // scfsi groups: g0 bands 0-5, g1 6-10, g2 11-15, g3 16-20
   localparam int SCFSI_G1_FIRST = 6;
   localparam int SCFSI_G2_FIRST = 11;
   localparam int SCFSI_G3_FIRST = 16;

   // Mixed block: long bands 0..7, then short bands from 3 upward
   localparam int MIXED_LONG_LAST   = 7;
   localparam int MIXED_SHORT_FIRST = 3;

   typedef logic [NUM_SFB_L-1:0][SF_W-1:0]              sf_l_t;
   typedef logic [NUM_SFB_S-1:0][NUM_WIN-1:0][SF_W-1:0] sf_s_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   function automatic logic [1:0] scfsi_group(input int band);
      if (band < SCFSI_G1_FIRST)      return 2'd0;
      else if (band < SCFSI_G2_FIRST) return 2'd1;
      else if (band < SCFSI_G3_FIRST) return 2'd2;
      else                            return 2'd3;
   endfunction

endpackage

// File: rtl/scalefac_store_if.sv
// scalefac_store_if -- bundle between the scalefactor parser, the store and
// the requantizer.
//   Capture side : si_valid + side-info fields, sf_l_in/sf_s_in,
//                  sf_in_valid, sf_in_ready
//   Stream side  : sf_data/sf_band/sf_win/sf_long/sf_last, sf_valid, sf_ready
//   Status       : overflow_err
// Modports: slave = the store itself, master = its environment.
interface scalefac_store_if #(
   parameter int SF_W = mp3_pkg::SF_W
);
   import mp3_pkg::*;

   logic                                        si_valid;
   logic                                        gr;
   logic                                        ch;
   logic [3:0]                                  scfsi;
   logic                                        window_switching_flag;
   logic [1:0]                                  block_type;
   logic                                        mixed_block_flag;
   logic [NUM_SFB_L-1:0][SF_W-1:0]              sf_l_in;
   logic [NUM_SFB_S-1:0][NUM_WIN-1:0][SF_W-1:0] sf_s_in;
   logic                                        sf_in_valid;
   logic                                        sf_in_ready;

   logic [SF_W-1:0]                             sf_data;
   logic [BAND_W-1:0]                           sf_band;
   logic [WIN_W-1:0]                            sf_win;
   logic                                        sf_long;
   logic                                        sf_last;
   logic                                        sf_valid;
   logic                                        sf_ready;

   logic                                        overflow_err;

   modport slave (
      input  si_valid, gr, ch, scfsi, window_switching_flag, block_type,
             mixed_block_flag, sf_l_in, sf_s_in, sf_in_valid, sf_ready,
      output sf_in_ready, sf_data, sf_band, sf_win, sf_long, sf_last,
             sf_valid, overflow_err
   );

   modport master (
      output si_valid, gr, ch, scfsi, window_switching_flag, block_type,
             mixed_block_flag, sf_l_in, sf_s_in, sf_in_valid, sf_ready,
      input  sf_in_ready, sf_data, sf_band, sf_win, sf_long, sf_last,
             sf_valid, overflow_err
   );

endinterface

// File: rtl/sf_band_seq.sv
// sf_band_seq -- band/window walker for one streamed scalefactor set.
//   clk, rst   clock, asynchronous active-high reset
//   start_i    load beat 0 for a set with shape {short_i, mixed_i}
//   adv_i      current beat accepted, move to the next one
//   band_o     band index of current beat
//   win_o      window of current beat (0 in long bands)
//   long_o     current beat is a long band
//   last_o     current beat is the final one of the set
// Orders: long 0..20; short band-major 0..11 x win 0..2;
// mixed long 0..7 then short 3..11 x win 0..2.
module sf_band_seq
   import mp3_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              short_i,
   input  logic              mixed_i,
   input  logic              adv_i,
   output logic [BAND_W-1:0] band_o,
   output logic [WIN_W-1:0]  win_o,
   output logic              long_o,
   output logic              last_o
);

   logic [BAND_W-1:0] band_q, band_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic              long_q, long_d;
   logic              mixed_q, mixed_d;

   // A mixed set never ends in its long part
   assign last_o = long_q ?
                   (!mixed_q && band_q == BAND_W'(NUM_SFB_L-1)) :
                   (band_q == BAND_W'(NUM_SFB_S-1) && win_q == WIN_W'(NUM_WIN-1));

   always_comb begin
      band_d  = band_q;
      win_d   = win_q;
      long_d  = long_q;
      mixed_d = mixed_q;
      if (start_i) begin
         band_d  = '0;
         win_d   = '0;
         long_d  = !short_i || mixed_i;
         mixed_d = mixed_i;
      end else if (adv_i && !last_o) begin
         if (long_q) begin
            if (mixed_q && band_q == BAND_W'(MIXED_LONG_LAST)) begin
               band_d = BAND_W'(MIXED_SHORT_FIRST);
               long_d = 1'b0;
            end else begin
               band_d = band_q + 1'b1;
            end
         end else if (win_q == WIN_W'(NUM_WIN-1)) begin
            win_d  = '0;
            band_d = band_q + 1'b1;
         end else begin
            win_d = win_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         band_q  <= '0;
         win_q   <= '0;
         long_q  <= 1'b0;
         mixed_q <= 1'b0;
      end else begin
         band_q  <= band_d;
         win_q   <= win_d;
         long_q  <= long_d;
         mixed_q <= mixed_d;
      end
   end

   assign band_o = band_q;
   assign win_o  = win_q;
   assign long_o = long_q;

endmodule

// File: rtl/scalefac_store.sv
// scalefac_store -- captures a parsed scalefactor set per granule/channel,
// merges scfsi-reused granule-0 long bands into granule 1, and streams the
// merged set one scalefactor per beat to the requantizer.
//   clk, rst  clock, asynchronous active-high reset
//   bus       scalefac_store_if.slave (side info, set capture, stream out,
//             sticky overflow_err)
// Parameters: SF_W bits per scalefactor, NCH channel stores.
// Optional feature: define SF_STORE_STEREO_EN for NCH stores indexed by ch;
// without it a single store is kept and ch is ignored.
module scalefac_store
   import mp3_pkg::*;
#(
   parameter int SF_W = mp3_pkg::SF_W,
   parameter int NCH  = 2
) (
   input logic             clk,
   input logic             rst,
   scalefac_store_if.slave bus
);

`ifdef SF_STORE_STEREO_EN
   localparam int NCH_EFF = NCH;
`else
   // Mono build: NCH stays in the parameter list but one store is kept
   localparam int NCH_EFF = (NCH > 0) ? 1 : 1;
`endif
   localparam int CH_W = (NCH_EFF > 1) ? $clog2(NCH_EFF) : 1;
   localparam int SB_W = $clog2(NUM_SFB_S);

   typedef logic [NUM_SFB_L-1:0][SF_W-1:0]              lset_t;
   typedef logic [NUM_SFB_S-1:0][NUM_WIN-1:0][SF_W-1:0] sset_t;

   state_t            state_q, state_d;
   logic              gr_q, gr_d;
   logic [3:0]        scfsi_q, scfsi_d;
   logic              wsf_q, wsf_d;
   logic [1:0]        bt_q, bt_d;
   logic              mbf_q, mbf_d;
   logic              overflow_q, overflow_d;
   lset_t             work_l_q, work_l_d;
   sset_t             work_s_q, work_s_d;
   lset_t             store_q [NCH_EFF];
   lset_t             store_d [NCH_EFF];
   logic [CH_W-1:0]   ch_idx;

   logic              streaming;
   logic              capture;
   logic              accept;
   logic              is_short;
   logic              is_mixed;
   logic [NUM_SFB_L-1:0] reuse;

   logic [BAND_W-1:0] seq_band;
   logic [WIN_W-1:0]  seq_win;
   logic              seq_long;
   logic              seq_last;

`ifdef SF_STORE_STEREO_EN
   logic ch_q, ch_d;

   always_comb begin
      ch_d = ch_q;
      if (bus.si_valid) ch_d = bus.ch;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ch_q <= 1'b0;
      else     ch_q <= ch_d;
   end

   assign ch_idx = CH_W'(ch_q);
`else
   assign ch_idx = '0;
`endif

   assign streaming = (state_q == ST_STREAM);
   assign capture   = (state_q == ST_IDLE) && bus.sf_in_valid;
   assign accept    = streaming && bus.sf_ready;
   // Block shape comes from the side info held before this edge, so a
   // simultaneous si_valid only affects the following set
   assign is_short  = wsf_q && (bt_q == 2'd2);
   assign is_mixed  = is_short && mbf_q;

   for (genvar gi = 0; gi < NUM_SFB_L; gi++) begin : g_reuse
      localparam logic [1:0] GRP = scfsi_group(gi);
      assign reuse[gi] = !is_short && gr_q && scfsi_q[GRP];
   end

   always_comb begin
      gr_d    = gr_q;
      scfsi_d = scfsi_q;
      wsf_d   = wsf_q;
      bt_d    = bt_q;
      mbf_d   = mbf_q;
      if (bus.si_valid) begin
         gr_d    = bus.gr;
         scfsi_d = bus.scfsi;
         wsf_d   = bus.window_switching_flag;
         bt_d    = bus.block_type;
         mbf_d   = bus.mixed_block_flag;
      end
   end

   always_comb begin
      work_l_d = work_l_q;
      work_s_d = work_s_q;
      store_d  = store_q;
      if (capture) begin
         for (int b = 0; b < NUM_SFB_L; b++) begin
            work_l_d[b] = reuse[b] ? store_q[ch_idx][b] : bus.sf_l_in[b];
         end
         work_s_d = bus.sf_s_in;
         // Granule 0 always refreshes the reuse source, whatever its block type
         if (!gr_q) store_d[ch_idx] = bus.sf_l_in;
      end
   end

   always_comb begin
      overflow_d = overflow_q | (bus.sf_in_valid && (state_q != ST_IDLE));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.sf_in_valid) state_d = ST_STREAM;
         ST_STREAM: if (accept && seq_last) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gr_q       <= 1'b0;
         scfsi_q    <= '0;
         wsf_q      <= 1'b0;
         bt_q       <= '0;
         mbf_q      <= 1'b0;
         overflow_q <= 1'b0;
         work_l_q   <= '0;
         work_s_q   <= '0;
         for (int c = 0; c < NCH_EFF; c++) store_q[c] <= '0;
      end else begin
         state_q    <= state_d;
         gr_q       <= gr_d;
         scfsi_q    <= scfsi_d;
         wsf_q      <= wsf_d;
         bt_q       <= bt_d;
         mbf_q      <= mbf_d;
         overflow_q <= overflow_d;
         work_l_q   <= work_l_d;
         work_s_q   <= work_s_d;
         store_q    <= store_d;
      end
   end

   sf_band_seq u_seq (
      .clk     (clk),
      .rst     (rst),
      .start_i (capture),
      .short_i (is_short),
      .mixed_i (is_mixed),
      .adv_i   (accept),
      .band_o  (seq_band),
      .win_o   (seq_win),
      .long_o  (seq_long),
      .last_o  (seq_last)
   );

   // Everything is driven from registers, so a stalled beat holds steady;
   // outside a stream the beat fields read as zero
   assign bus.sf_valid     = streaming;
   assign bus.sf_in_ready  = !streaming;
   assign bus.sf_data      = !streaming ? '0 :
                             seq_long ? work_l_q[seq_band] :
                             work_s_q[seq_band[SB_W-1:0]][seq_win];
   assign bus.sf_band      = streaming ? seq_band : '0;
   assign bus.sf_win       = streaming ? seq_win  : '0;
   assign bus.sf_long      = streaming && seq_long;
   assign bus.sf_last      = streaming && seq_last;
   assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_scalefac_store.sv
module tb_scalefac_store;
   import mp3_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scalefac_store_if #(.SF_W(W)) bus();

   scalefac_store #(.SF_W(W), .NCH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       gr;
      logic       ch;
      logic [3:0] scfsi;
      logic       wsf;
      logic [1:0] bt;
      logic       mbf;
      int         l_const;   // -1: sf_l_in[b] = b mod 16
      int         s_const;   // -1: sf_s_in[b][w] = (b+w) mod 16
      bit         stall;     // toggle sf_ready 1,0,1,0...
      int         exp_beats;
   } vec_t;

   vec_t vecs [10];

   int checks = 0;
   int errors = 0;

   int         model_store [2][NUM_SFB_L];
   logic [3:0] exp_data [64];
   logic [4:0] exp_band [64];
   logic [1:0] exp_win  [64];
   logic       exp_long [64];
   int         n_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic int grp_of(input int b);
      if (b <= 5)       return 0;
      else if (b <= 10) return 1;
      else if (b <= 15) return 2;
      else              return 3;
   endfunction

   function automatic int lval(input vec_t v, input int b);
      return (v.l_const < 0) ? (b % 16) : v.l_const;
   endfunction

   function automatic int sval(input vec_t v, input int b, input int w);
      return (v.s_const < 0) ? ((b + w) % 16) : v.s_const;
   endfunction

   task automatic push(input int d, input int b, input int w, input bit lg);
      exp_data[n_exp] = 4'(d);
      exp_band[n_exp] = 5'(b);
      exp_win[n_exp]  = 2'(w);
      exp_long[n_exp] = lg;
      n_exp++;
   endtask

   task automatic build_expected(input vec_t v);
      bit sh, mx;
      int chi, d;
      sh = v.wsf && (v.bt == 2'd2);
      mx = sh && v.mbf;
`ifdef SF_STORE_STEREO_EN
      chi = int'(v.ch);
`else
      chi = 0;
`endif
      n_exp = 0;
      if (!sh) begin
         for (int b = 0; b < 21; b++) begin
            d = (v.gr && v.scfsi[grp_of(b)]) ? model_store[chi][b] : lval(v, b);
            push(d, b, 0, 1'b1);
         end
      end else begin
         if (mx) for (int b = 0; b < 8; b++) push(lval(v, b), b, 0, 1'b1);
         for (int b = (mx ? 3 : 0); b < 12; b++)
            for (int w = 0; w < 3; w++) push(sval(v, b, w), b, w, 1'b0);
      end
      if (!v.gr) for (int b = 0; b < 21; b++) model_store[chi][b] = lval(v, b);
   endtask

   task automatic drive_fields(input vec_t v);
      bus.gr                    = v.gr;
      bus.ch                    = v.ch;
      bus.scfsi                 = v.scfsi;
      bus.window_switching_flag = v.wsf;
      bus.block_type            = v.bt;
      bus.mixed_block_flag      = v.mbf;
   endtask

   task automatic drive_data(input vec_t v);
      for (int b = 0; b < 21; b++) bus.sf_l_in[b] = W'(lval(v, b));
      for (int b = 0; b < 12; b++)
         for (int w = 0; w < 3; w++) bus.sf_s_in[b][w] = W'(sval(v, b, w));
   endtask

   // Entered #1 after the capture edge; leaves #1 after the edge following
   // the last accept.
   task automatic collect(input int exp_beats, input bit stall, input bit inject);
      int n;
      bit done, was_stalled;
      logic [13:0] hold, now_beat;
      n = 0;
      done = 1'b0;
      was_stalled = 1'b0;
      hold = '0;
      chk("first_beat_valid", 32'(bus.sf_valid), 32'd1);
      chk("busy_in_ready", 32'(bus.sf_in_ready), 32'd0);
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         now_beat = {bus.sf_valid, bus.sf_data, bus.sf_band, bus.sf_win,
                     bus.sf_long, bus.sf_last};
         if (was_stalled) chk($sformatf("stall_hold%0d", n), 32'(now_beat), 32'(hold));
         bus.sf_ready = stall ? ((cyc % 2) == 0) : 1'b1;
         if (bus.sf_valid && bus.sf_ready) begin
            if (n >= n_exp) begin
               chk("beat_overrun", 32'(n), 32'(n_exp));
               done = 1'b1;
            end else begin
               chk($sformatf("beat%0d", n),
                   32'({bus.sf_data, bus.sf_band, bus.sf_win, bus.sf_long, bus.sf_last}),
                   32'({exp_data[n], exp_band[n], exp_win[n], exp_long[n], (n == n_exp - 1)}));
               if (bus.sf_last) done = 1'b1;
            end
            n++;
         end
         was_stalled = bus.sf_valid && !bus.sf_ready;
         hold = now_beat;
         if (inject && cyc == 4) begin
            bus.sf_l_in = '1;
            bus.sf_s_in = '1;
            bus.sf_in_valid = 1'b1;
         end
         @(posedge clk); #1;
         bus.sf_in_valid = 1'b0;
      end
      chk("stream_done", 32'(done), 32'd1);
      chk("beat_count", 32'(n), 32'(exp_beats));
      chk("end_valid", 32'(bus.sf_valid), 32'd0);
      chk("end_in_ready", 32'(bus.sf_in_ready), 32'd1);
      bus.sf_ready = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input bit inject);
      drive_fields(v);
      bus.si_valid = 1'b1;
      @(posedge clk); #1;
      bus.si_valid = 1'b0;
      drive_data(v);
      bus.sf_in_valid = 1'b1;
      @(posedge clk); #1;
      bus.sf_in_valid = 1'b0;
      build_expected(v);
      collect(v.exp_beats, v.stall, inject);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t va, vb, vr, vz, vo;

      //          gr   ch   scfsi  wsf  bt    mbf   l   s  stall beats
      vecs[0] = '{1'b0,1'b0,4'h0, 1'b0,2'd0,1'b0, -1, -1, 1'b0, 21};
      vecs[1] = '{1'b0,1'b0,4'h0, 1'b0,2'd0,1'b0,  5, -1, 1'b1, 21};
      vecs[2] = '{1'b1,1'b0,4'h5, 1'b0,2'd0,1'b0,  9, -1, 1'b0, 21};
      vecs[3] = '{1'b0,1'b0,4'h0, 1'b1,2'd2,1'b0,  7, -1, 1'b0, 36};
      vecs[4] = '{1'b1,1'b0,4'hA, 1'b0,2'd0,1'b0,  2, -1, 1'b1, 21};
      vecs[5] = '{1'b0,1'b0,4'h0, 1'b1,2'd2,1'b1, -1, -1, 1'b1, 35};
      vecs[6] = '{1'b1,1'b0,4'hF, 1'b1,2'd2,1'b0,  3, 11, 1'b0, 36};
      vecs[7] = '{1'b0,1'b1,4'h0, 1'b0,2'd0,1'b0, 12, -1, 1'b0, 21};
      vecs[8] = '{1'b1,1'b0,4'hF, 1'b0,2'd0,1'b0,  1, -1, 1'b0, 21};
      vecs[9] = '{1'b1,1'b1,4'h8, 1'b1,2'd1,1'b0, 14, -1, 1'b1, 21};

      for (int c = 0; c < 2; c++)
         for (int b = 0; b < 21; b++) model_store[c][b] = 0;

      rst = 1'b1;
      bus.si_valid = 1'b0;
      bus.gr = 1'b0;
      bus.ch = 1'b0;
      bus.scfsi = '0;
      bus.window_switching_flag = 1'b0;
      bus.block_type = '0;
      bus.mixed_block_flag = 1'b0;
      bus.sf_l_in = '0;
      bus.sf_s_in = '0;
      bus.sf_in_valid = 1'b0;
      bus.sf_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.sf_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.sf_in_ready), 32'd1);
      chk("rst_overflow", 32'(bus.overflow_err), 32'd0);
      chk("rst_beat_fields", 32'({bus.sf_data, bus.sf_band, bus.sf_win, bus.sf_long, bus.sf_last}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_valid", 32'(bus.sf_valid), 32'd0);
      chk("idle_in_ready", 32'(bus.sf_in_ready), 32'd1);

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], 1'b0);
         $display("set %0d done: beats expected %0d, errors so far %0d", i, vecs[i].exp_beats, errors);
      end
      chk("no_overflow_yet", 32'(bus.overflow_err), 32'd0);

      // Input offered mid-stream is dropped and flagged
      vo = '{1'b0,1'b0,4'h0, 1'b0,2'd0,1'b0, 10, -1, 1'b0, 21};
      run_vec(vo, 1'b1);
      chk("overflow_set", 32'(bus.overflow_err), 32'd1);
      $display("overflow set done, errors so far %0d", errors);

      // si_valid together with sf_in_valid: capture uses the older fields
      va = '{1'b0,1'b0,4'h0, 1'b0,2'd0,1'b0,  4, -1, 1'b0, 21};
      vb = '{1'b1,1'b0,4'hF, 1'b0,2'd0,1'b0,  1, -1, 1'b0, 21};
      drive_fields(va);
      bus.si_valid = 1'b1;
      @(posedge clk); #1;
      drive_fields(vb);
      drive_data(va);
      bus.sf_in_valid = 1'b1;
      @(posedge clk); #1;
      bus.si_valid = 1'b0;
      bus.sf_in_valid = 1'b0;
      build_expected(va);
      collect(21, 1'b0, 1'b0);
      drive_data(vb);
      bus.sf_in_valid = 1'b1;
      @(posedge clk); #1;
      bus.sf_in_valid = 1'b0;
      build_expected(vb);
      collect(21, 1'b0, 1'b0);
      chk("overflow_sticky", 32'(bus.overflow_err), 32'd1);
      $display("simultaneous si/sf set done, errors so far %0d", errors);

      // Reset mid-stream aborts and clears the stores
      vr = '{1'b0,1'b0,4'h0, 1'b0,2'd0,1'b0,  6, -1, 1'b0, 21};
      drive_fields(vr);
      bus.si_valid = 1'b1;
      @(posedge clk); #1;
      bus.si_valid = 1'b0;
      drive_data(vr);
      bus.sf_in_valid = 1'b1;
      @(posedge clk); #1;
      bus.sf_in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_valid", 32'(bus.sf_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(bus.sf_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.sf_in_ready), 32'd1);
      chk("midrst_overflow", 32'(bus.overflow_err), 32'd0);
      chk("midrst_fields", 32'({bus.sf_data, bus.sf_band, bus.sf_win, bus.sf_long, bus.sf_last}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 2; c++)
         for (int b = 0; b < 21; b++) model_store[c][b] = 0;
      @(posedge clk); #1;
      vz = '{1'b1,1'b0,4'hF, 1'b0,2'd0,1'b0,  8, -1, 1'b0, 21};
      run_vec(vz, 1'b0);
      $display("reset mid-stream sequence done, errors so far %0d", errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
